// File: rtl/jtdd_rom_sched.sv
// Shares one SDRAM read port among N ROM consumers. Each slot keeps a one-word
// tagged cache, and misses are issued one at a time through the req/ack/data_rdy handshake.
//
// state     | meaning
// IDLE      | no access outstanding; picks a missing slot when not downloading
// WAIT_ACK  | sdram_req held high with a stable sdram_addr until sdram_ack
// WAIT_DATA | request accepted; waiting for data_rdy to fill cache[sel]
module jtdd_rom_sched #(
  parameter int N  = 4,
  parameter int AW = 22,
  parameter int DW = 32,
  parameter int RR = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            downloading,
  input  logic [N-1:0]    slot_cs,
  input  logic [N*AW-1:0] slot_addr,
  output logic [N-1:0]    slot_ok,
  output logic [N*DW-1:0] slot_dout,
  output logic            sdram_req,
  output logic [AW-1:0]   sdram_addr,
  input  logic            sdram_ack,
  input  logic            data_rdy,
  input  logic [DW-1:0]   data_read,
  output logic            refresh_en
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   sel, sel_nxt;
  logic [SW-1:0]   rr_ptr, rr_nxt;
  logic [SW-1:0]   winner;
  logic [AW-1:0]   win_addr;
  logic [CW-1:0]   scan;
  logic            found;
  logic            req_nxt;
  logic [AW-1:0]   addr_nxt;
  logic            fill;

  logic [N-1:0]    valid;
  logic [AW-1:0]   tag   [N];
  logic [DW-1:0]   cache [N];
  logic [N-1:0]    hit;
  logic [N-1:0]    miss;

  always_comb begin
    hit = '0;
    for (int i = 0; i < N; i++) begin
      hit[i] = slot_cs[i] & valid[i] & (slot_addr[i*AW +: AW] == tag[i]);
    end
    miss = slot_cs & ~hit;
  end

  always_comb begin
    slot_dout = '0;
    for (int i = 0; i < N; i++) begin
      slot_dout[i*DW +: DW] = cache[i];
    end
  end

  // Reset is sampled synchronously, so gate the status outputs while it is held.
  assign slot_ok    = rst ? '0 : hit;
  assign refresh_en = rst | ((state == IDLE) & ~(|miss));

  // Winner selection: rotating scan starting at rr_ptr, or lowest index first.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan     = '0;
    win_addr = '0;
    if (RR != 0) begin
      for (int k = 0; k < N; k++) begin
        scan = {1'b0, rr_ptr} + CW'(k);
        if (scan >= CW'(N)) scan = scan - CW'(N);
        if (!found && miss[scan[SW-1:0]]) begin
          winner = scan[SW-1:0];
          found  = 1'b1;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (miss[i]) winner = SW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (winner == SW'(i)) win_addr = slot_addr[i*AW +: AW];
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = sdram_req;
    addr_nxt  = sdram_addr;
    sel_nxt   = sel;
    fill      = 1'b0;
    if (downloading) begin
      state_nxt = IDLE;
      req_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|miss) begin
            sel_nxt   = winner;
            addr_nxt  = win_addr;
            req_nxt   = 1'b1;
            state_nxt = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            req_nxt = 1'b0;
            if (data_rdy) begin
              fill      = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          if (data_rdy) begin
            fill      = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end
      endcase
    end
    rr_nxt = rr_ptr;
    if (fill && (RR != 0)) begin
      rr_nxt = (sel == SW'(N - 1)) ? '0 : sel + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      sel        <= '0;
      rr_ptr     <= '0;
    end else begin
      state      <= state_nxt;
      sdram_req  <= req_nxt;
      sdram_addr <= addr_nxt;
      sel        <= sel_nxt;
      rr_ptr     <= rr_nxt;
    end
  end

  // The tag comes from the latched request address, never the live slot address.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < N; i++) begin
        tag[i]   <= '0;
        cache[i] <= '0;
      end
    end else if (downloading) begin
      valid <= '0;
    end else if (fill) begin
      valid[sel] <= 1'b1;
      tag[sel]   <= sdram_addr;
      cache[sel] <= data_read;
    end
  end

endmodule
